burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
- Parametrised N-client arbiter that time-multiplexes a single BurstRAM command port among cache controllers (icache, dcache, DMA, etc.).
- Each client raises a request and receives an exclusive grant. The arbiter muxes the winner's command, address, write data and mask onto the BurstRAM port, and holds the grant until the client signals that its burst is finished.
- Round-robin by default, giving starvation-free service for any N ≥ 2.
- BurstRAM read data and valid go to every client directly and do not pass through this block.

Parameters:
- NUM_CLIENTS, 2, number of requesters; must be ≥ 2.
- RAM_DEPTH_BITWIDTH, 4, BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64, BurstRAM data width (bytes = /8).
- SETTLE_CYCLES, 1, cycles after a grant during which cl_busy is ignored, so the client's busy flag has time to rise; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assertion, active-high
- cl_req  in  NUM_CLIENTS  per-client request, level
- cl_busy  in  NUM_CLIENTS  per-client busy; high while that client's burst transaction is in flight
- cl_cmd  in  NUM_CLIENTS  per-client BurstRAM cmd (0 read, 1 write)
- cl_cmd_en  in  NUM_CLIENTS  per-client cmd strobe
- cl_addr  in  NUM_CLIENTS*RAM_DEPTH_BITWIDTH  flattened addresses; client i uses slice i
- cl_wr_data  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH  flattened write data
- cl_data_mask  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH/8  flattened byte masks
- cl_gnt  out  NUM_CLIENTS  one-hot grant; registered
- br_cmd  out  1  muxed cmd
- br_cmd_en  out  1  muxed strobe
- br_addr  out  RAM_DEPTH_BITWIDTH  muxed address
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  muxed write data
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  muxed mask
- arb_idle  out  1  high when no grant is held

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, cl_gnt=0, arb_idle=1, rr pointer=0, settle counter=0.
  - Outputs forced low: br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0.
  - Reset mid-burst drops the grant immediately; recovering any in-flight BurstRAM state is the clients' responsibility.
- Mux: the br_* outputs are combinational selects of the granted client's slice. With no grant they are all 0 (br_cmd_en=0 guaranteed).
- Arbitration search (round-robin): scan from index ptr upward with wrap; the first i with cl_req[i]=1 wins.
- States:
  - IDLE: if any cl_req, the winner's cl_gnt bit is set at the next edge, settle counter loads SETTLE_CYCLES, and state goes to SETTLE. Latency from req to gnt is 1 cycle.
  - SETTLE: counter decrements; cl_busy is ignored. At 0, go to HOLD.
  - HOLD: grant held while cl_busy[g]=1. When cl_busy[g]=0:
    - ptr becomes g+1 mod NUM_CLIENTS.
    - If another request is pending (including g re-requesting; the pointer decides), the grant switches directly to the new winner on the same edge and state goes to SETTLE (zero idle gap).
    - Otherwise cl_gnt=0 and state goes to IDLE.
- cl_req may drop during SETTLE or HOLD; the grant is still released only via cl_busy low in HOLD.
- cl_req, cl_busy and command inputs of non-granted clients are ignored.
- cl_gnt is always one-hot or zero. arb_idle = (cl_gnt==0).
- Wrap: ptr = NUM_CLIENTS-1 followed by release gives ptr=0.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: winner is always the lowest-index requester; ptr is unused (it may be optimised away). Client 0 can starve the others.
- Undefined: round-robin as above.

Test Plan:
- NUM_CLIENTS=2, reset, no req:
  - Required: cl_gnt=0, br_cmd_en=0, arb_idle=1.
  - Then rst asserted mid-HOLD: cl_gnt=0 asynchronously.
- Client 1 request:
  - Stimulus: cl_req=2'b10, client 1 drives addr 4'hA, cmd_en=1, busy high for 6 cycles.
  - Required: cl_gnt=2'b10 one cycle later; br_addr=4'hA, br_cmd_en=1 while granted; gnt drops the cycle after busy falls.
- Contention, NUM_CLIENTS=4:
  - Stimulus: cl_req=4'b1111 held; each client's busy pulses 3 cycles after grant.
  - Required: grant order 0,1,2,3,0; no idle cycle between grants.
- Early busy fall, SETTLE_CYCLES=2:
  - Stimulus: client's busy low during the settle window.
  - Required: grant held until SETTLE expires, then released on first HOLD cycle.
- ARB_FIXED_PRIORITY_EN defined, NUM_CLIENTS=3:
  - Stimulus: cl_req=3'b111 held.
  - Required: client 0 re-granted every time; clients 1 and 2 never granted.
- Request withdrawn:
  - Stimulus: cl_req drops during SETTLE while that client's busy stays high 4 cycles.
  - Required: gnt held until busy low, then state returns to IDLE.

Source files
------------

// File: rtl/burst_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// burst_ram_arbiter_if
// Bundle of the client-side request/command lines and the muxed BurstRAM
// command port that together form the burst_ram_arbiter's bus.
//
// Parameters
//   NUM_CLIENTS              number of requesters
//   RAM_DEPTH_BITWIDTH       BurstRAM address width
//   RAM_BURST_DATA_BITWIDTH  BurstRAM data width (mask has one bit per byte)
//
// Signals (client i always owns slice i of each flattened vector)
//   cl_req, cl_busy, cl_cmd, cl_cmd_en      per-client scalars
//   cl_addr, cl_wr_data, cl_data_mask       flattened per-client vectors
//   cl_gnt                                  one-hot grant back to clients
//   br_cmd, br_cmd_en, br_addr,
//   br_wr_data, br_data_mask                muxed BurstRAM command port
//   arb_idle                                no grant currently held
//
// Modports
//   master  client side: drives requests/commands, observes grant and port
//   slave   arbiter side
// ----------------------------------------------------------------------------
interface burst_ram_arbiter_if #(
    parameter int NUM_CLIENTS             = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;

    logic [NUM_CLIENTS-1:0]                         cl_req;
    logic [NUM_CLIENTS-1:0]                         cl_busy;
    logic [NUM_CLIENTS-1:0]                         cl_cmd;
    logic [NUM_CLIENTS-1:0]                         cl_cmd_en;
    logic [NUM_CLIENTS*RAM_DEPTH_BITWIDTH-1:0]      cl_addr;
    logic [NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH-1:0] cl_wr_data;
    logic [NUM_CLIENTS*MASK_W-1:0]                  cl_data_mask;
    logic [NUM_CLIENTS-1:0]                         cl_gnt;

    logic                                           br_cmd;
    logic                                           br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]                  br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]             br_wr_data;
    logic [MASK_W-1:0]                              br_data_mask;
    logic                                           arb_idle;

    modport master (
        output cl_req, cl_busy, cl_cmd, cl_cmd_en, cl_addr, cl_wr_data, cl_data_mask,
        input  cl_gnt, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, arb_idle
    );

    modport slave (
        input  cl_req, cl_busy, cl_cmd, cl_cmd_en, cl_addr, cl_wr_data, cl_data_mask,
        output cl_gnt, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, arb_idle
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// ----------------------------------------------------------------------------
// burst_ram_arbiter
// Time-multiplexes one BurstRAM command port among NUM_CLIENTS cache/DMA
// clients. A requesting client gets an exclusive, registered one-hot grant
// one cycle after its request is seen; the grant is held through a short
// settle window (busy ignored) and then for as long as the client's busy
// flag stays high. On release the next requester is granted on the same
// edge, so back-to-back bursts have no idle gap. BurstRAM read data does not
// pass through this block.
//
// Ports
//   clk   clock
//   rst   asynchronous, active-high reset; drops any grant immediately
//   bus   burst_ram_arbiter_if.slave: client requests/commands in,
//         grant, muxed BurstRAM command port and arb_idle out
//
// Build option
//   ARB_FIXED_PRIORITY_EN  when defined the lowest-index requester always
//                          wins (client 0 can starve others); otherwise
//                          round-robin from a rotating pointer.
// ----------------------------------------------------------------------------
module burst_ram_arbiter #(
    parameter int NUM_CLIENTS             = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int SETTLE_CYCLES           = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    burst_ram_arbiter_if.slave    bus
);
    localparam int AW     = RAM_DEPTH_BITWIDTH;
    localparam int DW     = RAM_BURST_DATA_BITWIDTH;
    localparam int MW     = DW / 8;
    localparam int IW     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [NUM_CLIENTS-1:0] gnt_q,   gnt_d;
    logic [3:0]             cnt_q,   cnt_d;

    logic                   win_vld;
    logic [IW-1:0]          win_idx;
    logic                   busy_g;

    // Busy of the current grant holder only; other clients' busy is ignored.
    assign busy_g = |(gnt_q & bus.cl_busy);

`ifdef ARB_FIXED_PRIORITY_EN
    // ------------------------------------------------------------------
    // Fixed priority: lowest index wins, no rotation state needed.
    // ------------------------------------------------------------------
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (bus.cl_req[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Round-robin: search starts at the pointer and wraps.
    // ------------------------------------------------------------------
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] rr_base;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt_q[i]) gidx = IW'(i);
        end
    end

    assign nxt_ptr = (gidx == IW'(NUM_CLIENTS - 1)) ? '0 : gidx + IW'(1);

    // On a release in HOLD the pointer moves to holder+1 on the same edge as
    // the hand-over, so the hand-over search must already start from there.
    assign rr_base = (state_q == ST_HOLD) ? nxt_ptr : ptr_q;

    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            j = int'(rr_base) + k;
            if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
            if (!win_vld && bus.cl_req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_HOLD && !busy_g) ptr_d = nxt_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d          = 4'(SETTLE_CYCLES);
                    state_d        = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Window lasts SETTLE_CYCLES edges; busy is not looked at.
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!busy_g) begin
                    if (win_vld) begin
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        cnt_d          = 4'(SETTLE_CYCLES);
                        state_d        = ST_SETTLE;
                    end else begin
                        gnt_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command mux: AND-OR select on the one-hot grant, so with no grant
    // every br_* output (in particular br_cmd_en) is 0.
    // ------------------------------------------------------------------
    logic          mux_cmd;
    logic          mux_cmd_en;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wr_data;
    logic [MW-1:0] mux_mask;

    always_comb begin
        mux_cmd     = 1'b0;
        mux_cmd_en  = 1'b0;
        mux_addr    = '0;
        mux_wr_data = '0;
        mux_mask    = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt_q[i]) begin
                mux_cmd     = mux_cmd     | bus.cl_cmd[i];
                mux_cmd_en  = mux_cmd_en  | bus.cl_cmd_en[i];
                mux_addr    = mux_addr    | bus.cl_addr[i*AW +: AW];
                mux_wr_data = mux_wr_data | bus.cl_wr_data[i*DW +: DW];
                mux_mask    = mux_mask    | bus.cl_data_mask[i*MW +: MW];
            end
        end
    end

    assign bus.br_cmd       = mux_cmd;
    assign bus.br_cmd_en    = mux_cmd_en;
    assign bus.br_addr      = mux_addr;
    assign bus.br_wr_data   = mux_wr_data;
    assign bus.br_data_mask = mux_mask;
    assign bus.cl_gnt       = gnt_q;
    assign bus.arb_idle     = ~|gnt_q;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_burst_ram_arbiter
// Two arbiter instances (A: 2 clients, settle 1; B: 4 clients, settle 2)
// driven together. A transaction-level reference model tracks, per
// instance, who owns the port, how many edges the grant has been held and
// where the round-robin search starts; every cycle the grant, idle flag and
// muxed command port are compared against it, plus directed checks.
// ----------------------------------------------------------------------------
module tb_burst_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.NUM_CLIENTS(2), .RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) ifa ();
    burst_ram_arbiter_if #(.NUM_CLIENTS(4), .RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) ifb ();

    burst_ram_arbiter #(.NUM_CLIENTS(2), .RAM_DEPTH_BITWIDTH(AW),
                        .RAM_BURST_DATA_BITWIDTH(DW), .SETTLE_CYCLES(1))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    burst_ram_arbiter #(.NUM_CLIENTS(4), .RAM_DEPTH_BITWIDTH(AW),
                        .RAM_BURST_DATA_BITWIDTH(DW), .SETTLE_CYCLES(2))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: owner (-1 none), edges held, ptr.
    int m_own [2];
    int m_age [2];
    int m_ptr [2];
    int NN    [2] = '{2, 4};
    int SS    [2] = '{1, 2};

    function automatic int pick(int n, int p, logic [3:0] req);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < n; i++) if (req[i]) return i;
`else
        for (int k = 0; k < n; k++) if (req[(p + k) % n]) return (p + k) % n;
`endif
        return -1;
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_age[k] = 0; m_ptr[k] = 0;
        end
    endtask

    // One clock edge of the model: grant counts as held from edge 0; busy is
    // honoured only once more than SETTLE edges have passed since grant.
    task automatic mstep(int k, logic [3:0] req, logic [3:0] busy);
        if (m_own[k] < 0) begin
            m_own[k] = pick(NN[k], m_ptr[k], req);
            m_age[k] = 0;
        end else begin
            m_age[k]++;
            if (m_age[k] > SS[k] && !busy[m_own[k]]) begin
                m_ptr[k] = (m_own[k] + 1) % NN[k];
                m_own[k] = pick(NN[k], m_ptr[k], req);
                m_age[k] = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(string p, int o,
                              logic [3:0] gnt, logic idle, logic cmd_o, logic en_o,
                              logic [3:0] addr_o, logic [63:0] data_o, logic [7:0] mask_o,
                              logic [3:0] cmd_f, logic [3:0] en_f, logic [15:0] addr_f,
                              logic [255:0] data_f, logic [31:0] mask_f);
        logic [3:0]  e_gnt;
        logic        e_cmd, e_en;
        logic [3:0]  e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_mask;
        e_gnt = '0; e_cmd = 0; e_en = 0; e_addr = '0; e_data = '0; e_mask = '0;
        if (o >= 0) begin
            e_gnt[o] = 1'b1;
            e_cmd  = cmd_f[o];
            e_en   = en_f[o];
            e_addr = addr_f[o*4 +: 4];
            e_data = data_f[o*64 +: 64];
            e_mask = mask_f[o*8 +: 8];
        end
        chk({p, "_gnt"},    64'(gnt),    64'(e_gnt));
        chk({p, "_idle"},   64'(idle),   64'(o < 0));
        chk({p, "_cmd"},    64'(cmd_o),  64'(e_cmd));
        chk({p, "_cmd_en"}, 64'(en_o),   64'(e_en));
        chk({p, "_addr"},   64'(addr_o), 64'(e_addr));
        chk({p, "_wdata"},  data_o,      e_data);
        chk({p, "_mask"},   64'(mask_o), 64'(e_mask));
    endtask

    task automatic check_all();
        check_inst("a", m_own[0], 4'(ifa.cl_gnt), ifa.arb_idle, ifa.br_cmd, ifa.br_cmd_en,
                   ifa.br_addr, ifa.br_wr_data, ifa.br_data_mask,
                   4'(ifa.cl_cmd), 4'(ifa.cl_cmd_en), 16'(ifa.cl_addr),
                   256'(ifa.cl_wr_data), 32'(ifa.cl_data_mask));
        check_inst("b", m_own[1], ifb.cl_gnt, ifb.arb_idle, ifb.br_cmd, ifb.br_cmd_en,
                   ifb.br_addr, ifb.br_wr_data, ifb.br_data_mask,
                   ifb.cl_cmd, ifb.cl_cmd_en, ifb.cl_addr,
                   ifb.cl_wr_data, ifb.cl_data_mask);
    endtask

    // Inputs change only around the falling edge; model steps on the rising.
    task automatic tick();
        @(posedge clk);
        if (rst) mreset();
        else begin
            mstep(0, 4'(ifa.cl_req), 4'(ifa.cl_busy));
            mstep(1, ifb.cl_req, ifb.cl_busy);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        ifa.cl_req = '0; ifa.cl_busy = '0; ifa.cl_cmd = '0; ifa.cl_cmd_en = '0;
        ifa.cl_addr = '0; ifa.cl_wr_data = '0; ifa.cl_data_mask = '0;
        ifb.cl_req = '0; ifb.cl_busy = '0; ifb.cl_cmd = '0; ifb.cl_cmd_en = '0;
        ifb.cl_addr = '0; ifb.cl_wr_data = '0; ifb.cl_data_mask = '0;
    endtask

    task automatic rnd_bus();
        ifa.cl_cmd = 2'($urandom); ifa.cl_cmd_en = 2'($urandom);
        ifa.cl_addr = 8'($urandom); ifa.cl_data_mask = 16'($urandom);
        for (int i = 0; i < 4; i++) ifa.cl_wr_data[i*32 +: 32] = $urandom;
        ifb.cl_cmd = 4'($urandom); ifb.cl_cmd_en = 4'($urandom);
        ifb.cl_addr = 16'($urandom); ifb.cl_data_mask = $urandom;
        for (int i = 0; i < 8; i++) ifb.cl_wr_data[i*32 +: 32] = $urandom;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("async_rst_a_gnt", 64'(ifa.cl_gnt), 64'd0);
        chk("async_rst_b_gnt", 64'(ifb.cl_gnt), 64'd0);
        chk("async_rst_a_en",  64'(ifa.br_cmd_en), 64'd0);
        mreset();
        check_all();
    endtask

    int         gseq[$];
    logic [3:0] prev_g;
    int         bcnt[4];

    initial begin
        rst = 1'b1;
        clear_inputs();
        mreset();

        // Reset state
        #1;
        chk("rst_a_gnt",  64'(ifa.cl_gnt), 64'd0);
        chk("rst_a_idle", 64'(ifa.arb_idle), 64'd1);
        chk("rst_a_en",   64'(ifa.br_cmd_en), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single client 1 request on A, busy high for 6 cycles
        ifa.cl_req = 2'b10; ifa.cl_addr = 8'hA0; ifa.cl_cmd_en = 2'b10; ifa.cl_busy = 2'b10;
        tick();
        chk("c1_gnt_latency", 64'(ifa.cl_gnt), 64'h2);
        ifa.cl_req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("c1_gnt_held", 64'(ifa.cl_gnt), 64'h2);
            chk("c1_addr",     64'(ifa.br_addr), 64'hA);
            chk("c1_cmd_en",   64'(ifa.br_cmd_en), 64'h1);
        end
        ifa.cl_busy = 2'b00;
        tick();
        chk("c1_release", 64'(ifa.cl_gnt), 64'h0);

        // Reset mid-HOLD drops the grant asynchronously
        clear_inputs();
        ifa.cl_req = 2'b01; ifa.cl_busy = 2'b01;
        tick();
        ifa.cl_req = 2'b00;
        tick(); tick();
        chk("hold_before_rst", 64'(ifa.cl_gnt), 64'h1);
        async_reset();
        clear_inputs();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Contention on B: all request, each holder busy for 3 cycles
        ifb.cl_req = 4'b1111;
        for (int i = 0; i < 4; i++) bcnt[i] = 0;
        prev_g = ifb.cl_gnt;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c > 0) chk("cont_no_gap", 64'(ifb.arb_idle), 64'd0);
`ifdef ARB_FIXED_PRIORITY_EN
            chk("fixed_only_c0", 64'(ifb.cl_gnt), 64'h1);
`endif
            if (ifb.cl_gnt != 4'd0 && ifb.cl_gnt != prev_g) gseq.push_back($clog2(ifb.cl_gnt));
            prev_g = ifb.cl_gnt;
            for (int i = 0; i < 4; i++) begin
                bcnt[i] = ifb.cl_gnt[i] ? bcnt[i] + 1 : 0;
                ifb.cl_busy[i] = ifb.cl_gnt[i] && (bcnt[i] < 3);
            end
        end
`ifndef ARB_FIXED_PRIORITY_EN
        chk("cont_grants_seen", 64'(gseq.size() >= 5), 64'd1);
        if (gseq.size() >= 5) begin
            chk("cont_order0", 64'(gseq[0]), 64'd0);
            chk("cont_order1", 64'(gseq[1]), 64'd1);
            chk("cont_order2", 64'(gseq[2]), 64'd2);
            chk("cont_order3", 64'(gseq[3]), 64'd3);
            chk("cont_order4", 64'(gseq[4]), 64'd0);
        end
`endif
        ifb.cl_req = '0; ifb.cl_busy = '0;
        for (int c = 0; c < 6; c++) tick();
        chk("cont_drain_idle", 64'(ifb.arb_idle), 64'd1);

        // Early busy fall on B (settle 2): grant survives the settle window
        ifb.cl_req = 4'b0100; ifb.cl_busy = 4'b0000;
        tick();
        chk("early_gnt", 64'(ifb.cl_gnt), 64'h4);
        ifb.cl_req = 4'b0000;
        tick();
        chk("early_settle1", 64'(ifb.cl_gnt), 64'h4);
        tick();
        chk("early_settle2", 64'(ifb.cl_gnt), 64'h4);
        tick();
        chk("early_release", 64'(ifb.cl_gnt), 64'h0);

        // Request withdrawn during SETTLE on A, busy stays high 4 cycles
        ifa.cl_req = 2'b01; ifa.cl_busy = 2'b01;
        tick();
        chk("wd_gnt", 64'(ifa.cl_gnt), 64'h1);
        ifa.cl_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_held", 64'(ifa.cl_gnt), 64'h1);
        end
        ifa.cl_busy = 2'b00;
        tick();
        chk("wd_release", 64'(ifa.cl_gnt), 64'h0);
        tick();
        chk("wd_idle", 64'(ifa.arb_idle), 64'd1);

        // Randomized traffic on both instances, with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            ifa.cl_req = 2'($urandom);
            ifb.cl_req = 4'($urandom);
            for (int i = 0; i < 2; i++) ifa.cl_busy[i] = ($urandom_range(2, 0) != 0);
            for (int i = 0; i < 4; i++) ifb.cl_busy[i] = ($urandom_range(2, 0) != 0);
            rnd_bus();
            if (c == 200) begin
                async_reset();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
